// File: rtl/sram_pkg.sv
// Shared types and helpers for the asynchronous-SRAM controller.
package sram_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam int WCNT_W = 4;

    function automatic int beats_of(input int dw);
        return 32 / dw;
    endfunction

    function automatic int lanes_of(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// 32-bit bus to asynchronous SRAM bridge: splits words into beats, inserts
// wait states, assembles read beats and performs single-beat byte accesses.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter  int SRAM_AW = 20,
    parameter  int SRAM_DW = 16,
    parameter  int WAIT    = 1,
    localparam int BEATS   = beats_of(SRAM_DW),
    localparam int LANES   = lanes_of(SRAM_DW),
    localparam int LW      = $clog2(LANES),
    localparam int BW      = $clog2(BEATS),
    localparam int AW      = SRAM_AW + LW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               we,
    input  logic               be,
    input  logic [AW-1:0]      addr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    output logic               rdy,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_data,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [LANES-1:0]   sram_bm_n
);

    state_t              r_state, w_state_nx;
    logic [1:0]          r_beat, w_beat_nx;
    logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nx;
    logic [AW-1:0]       r_addr, w_addr_c;
    logic                r_we, r_be, w_we_c, w_be_c;
    logic [31:0]         r_wdata, w_wdata_c;
    logic [31:0]         r_rbuf, r_rdata, w_rword;
    logic [7:0]          w_rbyte;
    logic                w_accept, w_last, w_strobe_end;
    logic [SRAM_AW-1:0]  r_sram_addr;
    logic                r_ce_n, r_oe_n, r_we_n, r_drive;
    logic [LANES-1:0]    r_bm_n;
    logic [SRAM_DW-1:0]  r_wbus;

    function automatic logic [1:0] lane_of(input logic [AW-1:0] a);
        return a[1:0] & 2'(LANES - 1);
    endfunction

    function automatic logic [1:0] beat_of(input logic [AW-1:0] a);
        return a[1:0] >> LW;
    endfunction

    // SRAM word address of the enclosing 32-bit word with the beat index in its low bits.
    function automatic logic [SRAM_AW-1:0] beat_addr(input logic [AW-1:0] a, input logic [1:0] b);
        logic [SRAM_AW-1:0] base;
        base = a[AW-1:LW];
        return ((base >> BW) << BW) | SRAM_AW'(b);
    endfunction

    function automatic logic [LANES-1:0] lane_mask_n(input logic bytew, input logic [AW-1:0] a);
        if (!bytew) return '0;
        return ~(LANES'(1) << lane_of(a));
    endfunction

    function automatic logic [SRAM_DW-1:0] wr_bus(input logic [31:0] d, input logic bytew,
                                                  input logic [1:0] b);
        if (bytew) return {LANES{d[7:0]}};
        return SRAM_DW'(d >> (32'(b) * SRAM_DW));
    endfunction

    assign w_rword = (r_rbuf & ~(32'({SRAM_DW{1'b1}}) << (32'(r_beat) * SRAM_DW)))
                   | (32'(sram_data) << (32'(r_beat) * SRAM_DW));
    assign w_rbyte = 8'(sram_data >> (32'(lane_of(r_addr)) * 8));

    always_comb begin
        w_state_nx   = r_state;
        w_beat_nx    = r_beat;
        w_wcnt_nx    = r_wcnt;
        w_accept     = (r_state == IDLE) && en;
        w_we_c       = w_accept ? we      : r_we;
        w_be_c       = w_accept ? be      : r_be;
        w_addr_c     = w_accept ? addr    : r_addr;
        w_wdata_c    = w_accept ? data_in : r_wdata;
        w_last       = r_be || (r_beat == 2'(BEATS - 1));
        w_strobe_end = (r_state == STROBE) && (r_wcnt == WCNT_W'(WAIT - 1));
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nx = SETUP;
                    w_beat_nx  = be ? beat_of(addr) : 2'd0;
                end
            end
            SETUP: begin
                w_state_nx = STROBE;
                w_wcnt_nx  = '0;
            end
            STROBE: begin
                if (w_strobe_end) begin
                    w_wcnt_nx = '0;
                    if (r_we) begin
                        w_state_nx = HOLD;
                    end else if (w_last) begin
                        w_state_nx = IDLE;
                        w_beat_nx  = 2'd0;
                    end else begin
                        w_state_nx = SETUP;
                        w_beat_nx  = r_beat + 2'd1;
                    end
                end else begin
                    w_wcnt_nx = r_wcnt + 1'b1;
                end
            end
            HOLD: begin
                if (w_last) begin
                    w_state_nx = IDLE;
                    w_beat_nx  = 2'd0;
                end else begin
                    w_state_nx = SETUP;
                    w_beat_nx  = r_beat + 2'd1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Strobes are registered from the next state so the pins never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_wcnt      <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= 1'b0;
            r_wdata     <= '0;
            r_rbuf      <= '0;
            r_rdata     <= '0;
            r_sram_addr <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_drive     <= 1'b0;
            r_bm_n      <= '1;
            r_wbus      <= '0;
        end else begin
            r_state <= w_state_nx;
            r_beat  <= w_beat_nx;
            r_wcnt  <= w_wcnt_nx;
            if (w_accept) begin
                r_addr  <= addr;
                r_we    <= we;
                r_be    <= be;
                r_wdata <= data_in;
            end
            r_ce_n  <= (w_state_nx == IDLE);
            r_oe_n  <= !(((w_state_nx == SETUP) || (w_state_nx == STROBE)) && !w_we_c);
            r_we_n  <= !((w_state_nx == STROBE) && w_we_c);
            r_drive <= (w_state_nx != IDLE) && w_we_c;
            if (w_state_nx == SETUP) begin
                r_sram_addr <= beat_addr(w_addr_c, w_beat_nx);
                r_bm_n      <= lane_mask_n(w_be_c, w_addr_c);
                r_wbus      <= wr_bus(w_wdata_c, w_be_c, w_beat_nx);
            end else if (w_state_nx == IDLE) begin
                r_bm_n <= '1;
            end
            if (w_strobe_end && !r_we) begin
                r_rbuf <= w_rword;
                if (w_last) r_rdata <= r_be ? {24'h0, w_rbyte} : w_rword;
            end
        end
    end

    assign sram_data = r_drive ? r_wbus : 'z;
    assign sram_addr = r_sram_addr;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign sram_bm_n = r_bm_n;
    assign data_out  = r_rdata;
    assign rdy       = (r_state == IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: default 16-bit instance plus an 8-bit, WAIT=3 instance,
// each attached to a small behavioural SRAM.
module tb_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    logic probe;

    logic        en, we, be;
    logic [20:0] addr;
    logic [31:0] din, dout;
    logic        rdy, ce_n, oe_n, we_n;
    logic [19:0] sa;
    logic [1:0]  bm_n;
    wire  [15:0] sd;

    logic        en8, we8, be8;
    logic [19:0] addr8;
    logic [31:0] din8, dout8;
    logic        rdy8, ce8_n, oe8_n, we8_n;
    logic [19:0] sa8;
    logic [0:0]  bm8_n;
    wire  [7:0]  sd8;

    logic [15:0] mem16 [1024];
    logic [7:0]  mem8  [1024];

    int vectors = 0;
    int miscompares = 0;
    int bus_err = 0;
    logic [19:0] wlog[$];
    logic [1:0]  wbm[$];
    logic [19:0] rlog16[$];
    logic [19:0] rlog8[$];
    logic [31:0] sb[$];

    sram_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr),
        .data_in(din), .data_out(dout), .rdy(rdy), .sram_addr(sa), .sram_data(sd),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_bm_n(bm_n)
    );

    sram_ctrl #(.SRAM_AW(20), .SRAM_DW(8), .WAIT(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .we(we8), .be(be8), .addr(addr8),
        .data_in(din8), .data_out(dout8), .rdy(rdy8), .sram_addr(sa8), .sram_data(sd8),
        .sram_ce_n(ce8_n), .sram_oe_n(oe8_n), .sram_we_n(we8_n), .sram_bm_n(bm8_n)
    );

    // The probe drives zeros so a DUT that is not releasing the bus shows up as non-zero.
    assign sd  = probe ? 16'h0000 : (!ce_n && !oe_n) ? mem16[sa[9:0]] : 'z;
    assign sd8 = probe ? 8'h00 : (!ce8_n && !oe8_n) ? mem8[sa8[9:0]] : 'z;

    always @(negedge clk) begin
        if (rst_n && !ce_n && !we_n) begin
            for (int l = 0; l < 2; l++)
                if (!bm_n[l]) mem16[sa[9:0]][l*8 +: 8] <= sd[l*8 +: 8];
            wlog.push_back(sa);
            wbm.push_back(bm_n);
        end
        if (rst_n && !ce_n && !oe_n) begin
            rlog16.push_back(sa);
            if (!we_n || sd !== mem16[sa[9:0]]) bus_err++;
        end
        if (rst_n && !ce8_n && !we8_n && !bm8_n[0]) mem8[sa8[9:0]] <= sd8;
        if (rst_n && !ce8_n && !oe8_n) rlog8.push_back(sa8);
    end

    task automatic acc16(input logic w, input logic b, input logic [20:0] a,
                         input logic [31:0] d, input logic [31:0] exp, input int lat,
                         input string nm);
        int cyc;
        logic [31:0] e;
        if (!w) sb.push_back(exp);
        @(negedge clk);
        cyc = 0;
        while (!rdy && cyc < 100) begin @(negedge clk); cyc++; end
        en = 1'b1; we = w; be = b; addr = a; din = d;
        @(posedge clk); #1;
        en = 1'b0; we = ~w; be = ~b; addr = ~a; din = ~d;
        cyc = 0;
        while (!rdy && cyc < 200) begin @(posedge clk); #1; cyc++; end
        vectors++;
        if (cyc !== lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected %0d", nm, cyc, lat);
        end
        if (!w) begin
            e = sb.pop_front();
            vectors++;
            if (dout !== e) begin
                miscompares++;
                $display("FAIL %s data_out: got %h expected %h", nm, dout, e);
            end
        end
    endtask

    task automatic test_reset();
        probe = 1'b1;
        rst_n = 1'b0;
        en = 0; we = 0; be = 0; addr = '0; din = '0;
        en8 = 0; we8 = 0; be8 = 0; addr8 = '0; din8 = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ce_n, oe_n, we_n, bm_n} !== 5'b11111) begin
            miscompares++;
            $display("FAIL reset strobes: got %b expected 11111", {ce_n, oe_n, we_n, bm_n});
        end
        vectors++;
        if (sa !== 20'h0 || dout !== 32'h0) begin
            miscompares++;
            $display("FAIL reset addr/data_out: got %h/%h expected 0/0", sa, dout);
        end
        vectors++;
        if (sd !== 16'h0) begin
            miscompares++;
            $display("FAIL reset bus released: got %h expected 0000", sd);
        end
        rst_n = 1'b1;
        probe = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (rdy !== 1'b1 || rdy8 !== 1'b1 || {ce8_n, oe8_n, we8_n} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset rdy: got %b%b strobes8 %b expected 11 111", rdy, rdy8,
                     {ce8_n, oe8_n, we8_n});
        end
    endtask

    task automatic test_word_rw();
        wlog.delete(); wbm.delete(); rlog16.delete();
        acc16(1'b1, 1'b0, 21'h100, 32'hDEADBEEF, 32'h0, 6, "word write");
        vectors++;
        if (wlog.size() !== 2 || wlog[0] !== 20'h80 || wlog[1] !== 20'h81) begin
            miscompares++;
            $display("FAIL word write beats: got %0d strobes first %h expected 2 at 80,81",
                     wlog.size(), (wlog.size() > 0) ? wlog[0] : 20'hFFFFF);
        end
        vectors++;
        if (mem16[10'h80] !== 16'hBEEF || mem16[10'h81] !== 16'hDEAD) begin
            miscompares++;
            $display("FAIL word write mem: got %h_%h expected DEAD_BEEF",
                     mem16[10'h81], mem16[10'h80]);
        end
        rlog16.delete();
        acc16(1'b0, 1'b0, 21'h100, 32'h0, 32'hDEADBEEF, 4, "word read");
        vectors++;
        if (rlog16.size() !== 4 || rlog16[0] !== 20'h80 || rlog16[3] !== 20'h81) begin
            miscompares++;
            $display("FAIL word read beats: got %0d oe cycles expected 4 at 80,80,81,81",
                     rlog16.size());
        end
    endtask

    task automatic test_byte();
        acc16(1'b1, 1'b0, 21'h100, 32'h0, 32'h0, 6, "clear word");
        wlog.delete(); wbm.delete();
        acc16(1'b1, 1'b1, 21'h103, 32'h123456A5, 32'h0, 3, "byte write");
        vectors++;
        if (wlog.size() !== 1 || wlog[0] !== 20'h81 || wbm[0] !== 2'b01) begin
            miscompares++;
            $display("FAIL byte write beat: got %0d strobes addr %h bm %b expected 1 at 81 bm 01",
                     wlog.size(), (wlog.size() > 0) ? wlog[0] : 20'hFFFFF,
                     (wbm.size() > 0) ? wbm[0] : 2'bxx);
        end
        vectors++;
        if (dout !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL write keeps data_out: got %h expected deadbeef", dout);
        end
        acc16(1'b0, 1'b0, 21'h100, 32'h0, 32'hA5000000, 4, "word after byte");
        acc16(1'b0, 1'b1, 21'h103, 32'h0, 32'h000000A5, 2, "byte read hi");
        acc16(1'b0, 1'b1, 21'h102, 32'h0, 32'h00000000, 2, "byte read lo");
    endtask

    task automatic test_dw8();
        int cyc;
        mem8[10'h40] = 8'h11; mem8[10'h41] = 8'h22;
        mem8[10'h42] = 8'h33; mem8[10'h43] = 8'h44;
        sb.push_back(32'h44332211);
        rlog8.delete();
        @(negedge clk);
        en8 = 1'b1; we8 = 1'b0; be8 = 1'b0; addr8 = 20'h40;
        @(posedge clk); #1;
        en8 = 1'b0; addr8 = 20'hFFFFF;
        cyc = 0;
        while (!rdy8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        vectors++;
        if (cyc !== 16) begin
            miscompares++;
            $display("FAIL dw8 latency: got %0d expected 16", cyc);
        end
        vectors++;
        if (dout8 !== sb[0]) begin
            miscompares++;
            $display("FAIL dw8 data_out: got %h expected %h", dout8, sb[0]);
        end
        void'(sb.pop_front());
        vectors++;
        if (rlog8.size() !== 16) begin
            miscompares++;
            $display("FAIL dw8 beats: got %0d oe cycles expected 16", rlog8.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                vectors++;
                if (rlog8[i] !== 20'h40 + 20'(i / 4)) begin
                    miscompares++;
                    $display("FAIL dw8 beat addr %0d: got %h expected %h", i, rlog8[i],
                             20'h40 + 20'(i / 4));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        ow [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        ob [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [20:0] oa [6] = '{21'h200, 21'h200, 21'h204, 21'h204, 21'h201, 21'h200};
        logic [31:0] od [6] = '{32'hA1B2C3D4, 32'h0, 32'h0BADF00D, 32'h0, 32'h00000077, 32'h0};
        logic [31:0] oe [6] = '{32'h0, 32'hA1B2C3D4, 32'h0, 32'h0BADF00D, 32'h0, 32'hA1B277D4};
        int          ol [6] = '{6, 4, 6, 4, 3, 4};
        int cyc;
        logic [31:0] e;
        bus_err = 0;
        @(negedge clk);
        cyc = 0;
        while (!rdy && cyc < 100) begin @(negedge clk); cyc++; end
        for (int i = 0; i < 6; i++) begin
            en = 1'b1; we = ow[i]; be = ob[i]; addr = oa[i]; din = od[i];
            if (!ow[i]) sb.push_back(oe[i]);
            @(posedge clk); #1;
            cyc = 0;
            while (!rdy && cyc < 200) begin @(posedge clk); #1; cyc++; end
            vectors++;
            if (cyc !== ol[i]) begin
                miscompares++;
                $display("FAIL b2b op %0d gap: got %0d expected %0d", i, cyc, ol[i]);
            end
            if (!ow[i]) begin
                e = sb.pop_front();
                vectors++;
                if (dout !== e) begin
                    miscompares++;
                    $display("FAIL b2b op %0d data_out: got %h expected %h", i, dout, e);
                end
            end
        end
        en = 1'b0;
        vectors++;
        if (bus_err !== 0) begin
            miscompares++;
            $display("FAIL b2b bus contention: got %0d bad oe cycles expected 0", bus_err);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(negedge clk);
        en = 1'b1; we = 1'b1; be = 1'b0; addr = 21'h300; din = 32'h12345678;
        @(posedge clk); #1;
        en = 1'b0;
        cyc = 0;
        while (we_n && cyc < 20) begin @(posedge clk); #1; cyc++; end
        vectors++;
        if (we_n !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid reach strobe: got we_n %b expected 0", we_n);
        end
        #1;
        rst_n = 1'b0;
        probe = 1'b1;
        #1;
        vectors++;
        if ({ce_n, oe_n, we_n, bm_n} !== 5'b11111) begin
            miscompares++;
            $display("FAIL reset_mid strobes: got %b expected 11111", {ce_n, oe_n, we_n, bm_n});
        end
        vectors++;
        if (sd !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid bus released: got %h expected 0000", sd);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        probe = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (rdy !== 1'b1 || dout !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid release: got rdy %b data_out %h expected 1 00000000",
                     rdy, dout);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem16[i] = 16'h0;
            mem8[i]  = 8'h0;
        end
        test_reset();
        test_word_rw();
        test_byte();
        test_dw8();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
